line_burst_adapter: RTL and testbench
=====================================

Name: line_burst_adapter

Overview:
Responder for the cache's 256-bit line interface (pmem_* side of the cache). It converts one line read or write into a 4-beat, 64-bit burst toward physical memory, and returns a single-cycle resp_o to the cache. It sits between the cache (or arbiter) and the burst memory model, owning all beat sequencing and line assembly/disassembly.

Parameters:
s_line, 256, line width in bits
s_burst, 64, beat width in bits
n_beats, s_line/s_burst (4), beats per line; must be a power of two
s_offset, 5, line-offset bits cleared on the outgoing address

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
line_i  input  256  write line from cache (pmem_wdata)
line_o  output  256  assembled read line to cache (pmem_rdata)
address_i  input  32  line address from cache (pmem_address)
read_i  input  1  line read request (pmem_read)
write_i  input  1  line write request (pmem_write)
resp_o  output  1  one-cycle completion pulse (pmem_resp)
burst_i  input  64  read beat from memory
burst_o  output  64  write beat to memory
address_o  output  32  burst base address, low s_offset bits zero
read_o  output  1  burst read request, held for the whole burst
write_o  output  1  burst write request, held for the whole burst
resp_i  input  1  memory beat acknowledge, one per beat

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, resp_o/read_o/write_o 0, address_o 0, burst_o 0, line_o 0, line buffer 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - write_i=1 -> latch line_i into buffer, latch address_o={address_i[31:5],5'b0}, counter=0, go WR.
  - Otherwise read_i=1 -> latch address, counter=0, go RD.
  - Write has priority when both are high.
  - Requests are sampled only in IDLE.
- RD:
  - read_o=1 (registered; first asserted cycle after acceptance).
  - Each cycle with resp_i=1: buffer[64*cnt +: 64] <= burst_i; cnt++.
  - On the beat with cnt==n_beats-1 -> go DONE; read_o drops the same edge.
- WR:
  - write_o=1; burst_o = buffer[64*cnt +: 64] (combinational from counter).
  - Each resp_i advances cnt. The last beat goes to DONE; write_o drops.
- resp_i outside RD/WR is ignored. No beat is ever skipped or duplicated; resp_i gaps of any length only stall.
- DONE: resp_o=1 for exactly one cycle, line_o = buffer (valid this cycle and held stable until the next read's DONE), then go IDLE.
- Latency: with resp_i constantly 1, a request accepted at edge 0 gives read_o/write_o high for cycles 1-4 and resp_o high in cycle 5. The next request can be accepted at the edge ending the DONE cycle's successor (IDLE cycle).
- address_o is constant for the whole burst; memory increments internally.
- Counter is log2(n_beats) bits and wraps to 0 after the last beat.
- Requester contract: hold read_i/write_i and address_i until resp_o. Deasserting a request mid-burst has no effect; the burst completes.
- Reset asserted mid-burst: immediate return to IDLE, read_o/write_o drop asynchronously, partial line discarded.

Optional Feature:
LINE_ADAPTER_PROTOCOL_CHECK_EN
- Defined: simulation-only concurrent assertions flag each of these with $error:
  - read_i and write_i both high in IDLE
  - request dropped or address_i changed before resp_o
  - resp_i high while in IDLE or DONE
  - read_o and write_o both high
- Undefined: no checks are compiled; RTL behaviour is identical.

Test Plan:
- Read, resp_i always 1, address_i=0x0000_1234, burst_i beats 0xA0..,0xA1..,0xA2..,0xA3.. -> address_o=0x0000_1220; read_o high 4 cycles; resp_o in cycle 5; line_o={beat3,beat2,beat1,beat0}.
- Write line_i=256'h0123...CDEF, resp_i pattern 1,0,0,1,1,0,1 -> burst_o presents line_i[63:0],[127:64],[191:128],[255:192] in order, each held until acked; resp_o exactly once, after the 4th ack.
- read_i and write_i both high in IDLE -> WR burst performed, read_o never asserted.
- Back-to-back write then read to 0x40 and 0x80 -> two independent bursts, two resp_o pulses, at least one IDLE cycle between them, correct address_o each time.
- rst pulled low after 2 read beats -> read_o=0 immediately, no resp_o; next read after reset returns a full, correct line.
- resp_i=1 while IDLE with no request -> no state change, no resp_o, counter stays 0.

Source files
------------

// File: rtl/line_burst_adapter_if.sv
// Cache-line side and burst-memory side signals of the line burst adapter.
// The slave modport is the adapter's view; master is the surrounding environment.
interface line_burst_adapter_if #(
  parameter int unsigned SLine  = 256,
  parameter int unsigned SBurst = 64,
  parameter int unsigned AddrW  = 32
);
  logic [SLine-1:0]  line_i;
  logic [SLine-1:0]  line_o;
  logic [AddrW-1:0]  address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [SBurst-1:0] burst_i;
  logic [SBurst-1:0] burst_o;
  logic [AddrW-1:0]  address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/line_burst_adapter.sv
// Converts one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
// Optional protocol assertions are compiled in with LINE_ADAPTER_PROTOCOL_CHECK_EN.
module line_burst_adapter #(
  parameter int unsigned SLine   = 256,
  parameter int unsigned SBurst  = 64,
  parameter int unsigned NBeats  = SLine / SBurst,
  parameter int unsigned SOffset = 5,
  parameter int unsigned AddrW   = 32
) (
  input logic                 clk,
  input logic                 rst,
  line_burst_adapter_if.slave bus
);

  localparam int unsigned CntW = $clog2(NBeats);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [NBeats-1:0][SBurst-1:0]  buf_q, buf_d;
  logic [AddrW-1:0]               addr_q, addr_d;
  logic [SLine-1:0]               line_q, line_d;
  logic                           last_beat;

  assign last_beat = (cnt_q == CntW'(NBeats - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        // Write wins when both requests are present.
        if (bus.write_i) begin
          buf_d   = bus.line_i;
          addr_d  = {bus.address_i[AddrW-1:SOffset], {SOffset{1'b0}}};
          cnt_d   = '0;
          state_d = StWr;
        end else if (bus.read_i) begin
          addr_d  = {bus.address_i[AddrW-1:SOffset], {SOffset{1'b0}}};
          cnt_d   = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        if (bus.resp_i) begin
          buf_d[cnt_q] = bus.burst_i;
          cnt_d        = cnt_q + CntW'(1);
          if (last_beat) begin
            // line_o only moves on read completion so it survives intervening writes.
            line_d  = buf_d;
            state_d = StDone;
          end
        end
      end
      StWr: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  assign bus.read_o    = (state_q == StRd);
  assign bus.write_o   = (state_q == StWr);
  assign bus.resp_o    = (state_q == StDone);
  assign bus.address_o = addr_q;
  assign bus.line_o    = line_q;
  assign bus.burst_o   = bus.write_o ? buf_q[cnt_q] : '0;

`ifdef LINE_ADAPTER_PROTOCOL_CHECK_EN
  a_req_excl: assert property (@(posedge clk) disable iff (!rst)
    (state_q == StIdle) |-> !(bus.read_i && bus.write_i))
    else $error("read_i and write_i both high in IDLE");

  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    (state_q inside {StRd, StWr}) |-> ((bus.read_i || bus.write_i) && $stable(bus.address_i)))
    else $error("request dropped or address_i changed before resp_o");

  a_resp_idle: assert property (@(posedge clk) disable iff (!rst)
    (state_q inside {StIdle, StDone}) |-> !bus.resp_i)
    else $error("resp_i high while in IDLE or DONE");

  a_burst_excl: assert property (@(posedge clk) disable iff (!rst)
    !(bus.read_o && bus.write_o))
    else $error("read_o and write_o both high");
`endif

endmodule

// File: tb/tb_line_burst_adapter.sv
// Randomized bench for line_burst_adapter: a transaction-level model predicts
// burst flags, beat order, address, resp_o timing and the held read line.
module tb_line_burst_adapter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_burst_adapter_if bus ();

  line_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [255:0] last_line = '0;
  logic [31:0]  last_addr = '0;
  bit           ack_pat[$];

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit next_ack(input int gap_pct);
    if (ack_pat.size() > 0) return ack_pat.pop_front();
    return ($urandom_range(99) >= gap_pct);
  endfunction

  // Caller is at a negedge with the DUT idle; the request is accepted at the next posedge.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int gap_pct);
    int acks = 0;
    int cyc  = 0;
    bit ack;
    bit is_wr = wr;
    logic [31:0] exp_addr = addr & 32'hFFFF_FFE0;
    bus.write_i   = wr;
    bus.read_i    = rd;
    bus.address_i = addr;
    bus.line_i    = wline;
    bus.resp_i    = 1'($urandom_range(1));
    bus.burst_i   = {$urandom, $urandom};
    while (acks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.line_i = rand_line();
      check_eq("burst_flag", is_wr ? bus.write_o : bus.read_o, 1'b1);
      check_eq("other_flag", is_wr ? bus.read_o : bus.write_o, 1'b0);
      check_eq("resp_busy",  bus.resp_o, 1'b0);
      check_eq("address_o",  bus.address_o, exp_addr);
      check_eq("line_hold",  bus.line_o, last_line);
      if (is_wr) check_eq("write_beat", bus.burst_o, wline[64*acks +: 64]);
      ack = next_ack(gap_pct);
      bus.resp_i  = ack;
      bus.burst_i = (ack && !is_wr) ? rline[64*acks +: 64] : {$urandom, $urandom};
      if (ack) acks++;
    end
    check_eq("beats_before_timeout", acks, 4);
    @(negedge clk);
    bus.resp_i = 1'($urandom_range(1));
    if (!is_wr) last_line = rline;
    last_addr = exp_addr;
    check_eq("resp_done",   bus.resp_o, 1'b1);
    check_eq("read_done",   bus.read_o, 1'b0);
    check_eq("write_done",  bus.write_o, 1'b0);
    check_eq("line_done",   bus.line_o, last_line);
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = $urandom;
    @(negedge clk);
    bus.resp_i = 1'($urandom_range(1));
    check_eq("resp_idle",  bus.resp_o, 1'b0);
    check_eq("read_idle",  bus.read_o, 1'b0);
    check_eq("write_idle", bus.write_o, 1'b0);
    check_eq("line_idle",  bus.line_o, last_line);
    check_eq("addr_idle",  bus.address_o, last_addr);
  endtask

  initial begin
    logic [255:0] rl;
    logic [255:0] wl;
    bit wr;
    bit rd;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_read_o",  bus.read_o, 1'b0);
    check_eq("rst_write_o", bus.write_o, 1'b0);
    check_eq("rst_resp_o",  bus.resp_o, 1'b0);
    check_eq("rst_addr_o",  bus.address_o, 32'h0);
    check_eq("rst_burst_o", bus.burst_o, 64'h0);
    check_eq("rst_line_o",  bus.line_o, 256'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed read, resp_i always 1.
    rl = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
          64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    run_txn(1'b0, 1'b1, 32'h0000_1234, '0, rl, 0);

    // Directed write with a stalling ack pattern.
    wl = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABB89ABCDEF;
    ack_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_txn(1'b1, 1'b0, 32'h0000_2000, wl, '0, 0);

    // Both requests: write must win.
    run_txn(1'b1, 1'b1, 32'h0000_3010, rand_line(), '0, 30);

    // Back-to-back write then read.
    run_txn(1'b1, 1'b0, 32'h0000_0040, rand_line(), '0, 0);
    run_txn(1'b0, 1'b1, 32'h0000_0080, '0, rand_line(), 0);

    // resp_i while idle with no request must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.resp_i = 1'b1;
      @(negedge clk);
      check_eq("idle_ack_resp",  bus.resp_o, 1'b0);
      check_eq("idle_ack_read",  bus.read_o, 1'b0);
      check_eq("idle_ack_write", bus.write_o, 1'b0);
      check_eq("idle_ack_addr",  bus.address_o, last_addr);
    end
    // First beat presented must still be beat 0.
    run_txn(1'b1, 1'b0, 32'h0000_5000, rand_line(), '0, 20);

    // Reset in the middle of a read after two beats.
    bus.read_i = 1'b1; bus.address_i = 32'h0000_6000; bus.resp_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("prereset_read", bus.read_o, 1'b1);
      bus.resp_i  = (i < 2);
      bus.burst_i = {$urandom, $urandom};
    end
    rst = 1'b0;
    #1;
    check_eq("reset_read_drop", bus.read_o, 1'b0);
    check_eq("reset_resp",      bus.resp_o, 1'b0);
    check_eq("reset_addr",      bus.address_o, 32'h0);
    check_eq("reset_line",      bus.line_o, 256'h0);
    last_line = '0;
    last_addr = '0;
    bus.read_i = 1'b0; bus.resp_i = 1'b0;
    @(negedge clk);
    check_eq("in_reset_resp", bus.resp_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 1'b1, 32'h0000_6000, '0, rand_line(), 0);

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      wr = 1'($urandom_range(1));
      rd = wr ? 1'($urandom_range(1)) : 1'b1;
      run_txn(wr, rd, $urandom, rand_line(), rand_line(), $urandom_range(60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
